// File: rtl/match_req_dispatcher_if.sv
// Bus bundle for match_req_dispatcher: request bundle in, per-channel requests out,
// unroutable-lane report and the backpressure stall counter.
`ifndef LAZY_LEN
`define LAZY_LEN 4
`endif
`ifndef NUM_MATCH_REQ_CH
`define NUM_MATCH_REQ_CH 4
`endif
`ifndef SEQ_OFFSET_BITS
`define SEQ_OFFSET_BITS 16
`endif

interface match_req_dispatcher_if #(
  parameter int LAZY_LEN = `LAZY_LEN,
  parameter int NUM_CH   = `NUM_MATCH_REQ_CH,
  parameter int OFS_BITS = `SEQ_OFFSET_BITS,
  parameter int TAG_BITS = 8
);
  localparam int LANE_W = (LAZY_LEN > 1) ? $clog2(LAZY_LEN) : 1;

  logic                         in_valid;
  logic                         in_ready;
  logic [LAZY_LEN-1:0]          in_req_mask;
  logic [LAZY_LEN*OFS_BITS-1:0] in_offset;
  logic [LAZY_LEN*NUM_CH-1:0]   in_route_map;
  logic [TAG_BITS-1:0]          in_tag;

  logic [NUM_CH-1:0]            ch_valid;
  logic [NUM_CH-1:0]            ch_ready;
  logic [NUM_CH*OFS_BITS-1:0]   ch_offset;
  logic [NUM_CH*LANE_W-1:0]     ch_lane;
  logic [NUM_CH*TAG_BITS-1:0]   ch_tag;

  logic                         drop_valid;
  logic [LAZY_LEN-1:0]          drop_mask;
  logic [TAG_BITS-1:0]          drop_tag;

  logic [31:0]                  perf_stall_cnt;

  modport slave (
    input  in_valid, in_req_mask, in_offset, in_route_map, in_tag, ch_ready,
    output in_ready, ch_valid, ch_offset, ch_lane, ch_tag,
           drop_valid, drop_mask, drop_tag, perf_stall_cnt
  );

  modport master (
    output in_valid, in_req_mask, in_offset, in_route_map, in_tag, ch_ready,
    input  in_ready, ch_valid, ch_offset, ch_lane, ch_tag,
           drop_valid, drop_mask, drop_tag, perf_stall_cnt
  );
endinterface

// File: rtl/match_req_dispatcher.sv
// Splits an accepted lane bundle into per-channel match requests (lowest eligible channel,
// ascending lane order per channel). Define MATCH_REQ_DISPATCH_PERF_EN to build the stall counter.
`ifndef LAZY_LEN
`define LAZY_LEN 4
`endif
`ifndef NUM_MATCH_REQ_CH
`define NUM_MATCH_REQ_CH 4
`endif
`ifndef SEQ_OFFSET_BITS
`define SEQ_OFFSET_BITS 16
`endif

module match_req_dispatcher #(
  parameter int LAZY_LEN = `LAZY_LEN,
  parameter int NUM_CH   = `NUM_MATCH_REQ_CH,
  parameter int OFS_BITS = `SEQ_OFFSET_BITS,
  parameter int TAG_BITS = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  match_req_dispatcher_if.slave bus
);
  localparam int LANE_W = (LAZY_LEN > 1) ? $clog2(LAZY_LEN) : 1;
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic {
    IDLE     = 1'b0,
    DISPATCH = 1'b1
  } state_e;

  state_e                       state_q, state_d;
  logic [LAZY_LEN-1:0]          pending_q, pending_d;
  logic [CH_W-1:0]              bind_q [LAZY_LEN];
  logic [LAZY_LEN*OFS_BITS-1:0] lane_ofs_q;
  logic [TAG_BITS-1:0]          bundle_tag_q;

  logic [NUM_CH-1:0]            ch_valid_q;
  logic [NUM_CH*OFS_BITS-1:0]   ch_ofs_q;
  logic [NUM_CH*LANE_W-1:0]     ch_lane_q;
  logic [NUM_CH*TAG_BITS-1:0]   ch_tag_q;

  logic                         drop_valid_q;
  logic [LAZY_LEN-1:0]          drop_mask_q;
  logic [TAG_BITS-1:0]          drop_tag_q;

  logic                         accept;
  logic [LAZY_LEN-1:0]          routable;
  logic [LAZY_LEN-1:0]          unroutable;
  logic [CH_W-1:0]              first_ch [LAZY_LEN];
  logic [NUM_CH-1:0]            ch_free;
  logic [NUM_CH-1:0]            ch_load;
  logic [LANE_W-1:0]            sel_lane [NUM_CH];

  assign accept  = bus.in_valid && (state_q == IDLE);
  assign ch_free = ~ch_valid_q | bus.ch_ready;

  // Descending scans let the lowest index win without a separate found flag.
  always_comb begin
    for (int i = 0; i < LAZY_LEN; i++) begin
      routable[i]   = bus.in_req_mask[i] &&  (|bus.in_route_map[i*NUM_CH +: NUM_CH]);
      unroutable[i] = bus.in_req_mask[i] && !(|bus.in_route_map[i*NUM_CH +: NUM_CH]);
      first_ch[i]   = '0;
      for (int j = NUM_CH - 1; j >= 0; j--) begin
        if (bus.in_route_map[i*NUM_CH + j]) first_ch[i] = CH_W'(j);
      end
    end
  end

  always_comb begin
    for (int j = 0; j < NUM_CH; j++) begin
      ch_load[j]  = 1'b0;
      sel_lane[j] = '0;
      for (int i = LAZY_LEN - 1; i >= 0; i--) begin
        if (pending_q[i] && (bind_q[i] == CH_W'(j))) begin
          ch_load[j]  = ch_free[j] && (state_q == DISPATCH);
          sel_lane[j] = LANE_W'(i);
        end
      end
    end
  end

  // NOTE: every variable driven here gets its default first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          pending_d = routable;
          if (|routable) state_d = DISPATCH;
        end
      end
      DISPATCH: begin
        for (int j = 0; j < NUM_CH; j++) begin
          if (ch_load[j]) pending_d[sel_lane[j]] = 1'b0;
        end
        if (pending_d == '0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so all registers sample pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pending_q <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
    end
  end

  // NOTE: the bundle data registers are cleared on reset too, so nothing stale can be observed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LAZY_LEN; i++) bind_q[i] <= '0;
      lane_ofs_q   <= '0;
      bundle_tag_q <= '0;
    end else if (accept) begin
      for (int i = 0; i < LAZY_LEN; i++) bind_q[i] <= first_ch[i];
      lane_ofs_q   <= bus.in_offset;
      bundle_tag_q <= bus.in_tag;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch_valid_q <= '0;
      ch_ofs_q   <= '0;
      ch_lane_q  <= '0;
      ch_tag_q   <= '0;
    end else begin
      for (int j = 0; j < NUM_CH; j++) begin
        if (ch_load[j]) begin
          ch_valid_q[j]                       <= 1'b1;
          ch_ofs_q[j*OFS_BITS +: OFS_BITS]    <= lane_ofs_q[sel_lane[j]*OFS_BITS +: OFS_BITS];
          ch_lane_q[j*LANE_W +: LANE_W]       <= sel_lane[j];
          ch_tag_q[j*TAG_BITS +: TAG_BITS]    <= bundle_tag_q;
        end else if (bus.ch_ready[j]) begin
          ch_valid_q[j] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_valid_q <= 1'b0;
      drop_mask_q  <= '0;
      drop_tag_q   <= '0;
    end else begin
      drop_valid_q <= accept && (|unroutable);
      if (accept) begin
        drop_mask_q <= unroutable;
        drop_tag_q  <= bus.in_tag;
      end
    end
  end

`ifdef MATCH_REQ_DISPATCH_PERF_EN
  logic [31:0] stall_cnt_q;
  logic        stall;

  assign stall = |(ch_valid_q & ~bus.ch_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else if (stall && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign bus.perf_stall_cnt = stall_cnt_q;
`else
  assign bus.perf_stall_cnt = '0;
`endif

  assign bus.in_ready   = (state_q == IDLE);
  assign bus.ch_valid   = ch_valid_q;
  assign bus.ch_offset  = ch_ofs_q;
  assign bus.ch_lane    = ch_lane_q;
  assign bus.ch_tag     = ch_tag_q;
  assign bus.drop_valid = drop_valid_q;
  assign bus.drop_mask  = drop_mask_q;
  assign bus.drop_tag   = drop_tag_q;

endmodule

// File: tb/tb_match_req_dispatcher.sv
// Directed bench for match_req_dispatcher (LAZY_LEN=4, NUM_CH=4): vector table plus
// hand-written shared-channel, stall and mid-dispatch reset sequences.
module tb_match_req_dispatcher;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

`ifdef MATCH_REQ_DISPATCH_PERF_EN
  localparam logic [31:0] EXP_STALL = 32'd5;
`else
  localparam logic [31:0] EXP_STALL = 32'd0;
`endif

  match_req_dispatcher_if #(.LAZY_LEN(4), .NUM_CH(4), .OFS_BITS(16), .TAG_BITS(8)) bus ();

  match_req_dispatcher #(.LAZY_LEN(4), .NUM_CH(4), .OFS_BITS(16), .TAG_BITS(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] ofs_of(input int v, input int i);
    return 16'(32'hA000 + v * 256 + i * 17);
  endfunction

  task automatic drive_bundle(input int v, input logic [3:0] mask, input logic [15:0] route,
                              input logic [7:0] tag);
    bus.in_valid     = 1'b1;
    bus.in_req_mask  = mask;
    bus.in_route_map = route;
    bus.in_tag       = tag;
    for (int i = 0; i < 4; i++) bus.in_offset[i*16 +: 16] = ofs_of(v, i);
  endtask

  task automatic drain(input string name);
    int k;
    k = 0;
    while (!(bus.in_ready && bus.ch_valid == 4'b0000) && k < 20) begin
      step();
      k++;
    end
    check({name, " drain"}, 32'(k < 20), 32'd1);
  endtask

  typedef struct {
    logic [3:0]  mask;
    logic [15:0] route;
    logic [7:0]  tag;
    logic        exp_ready_e;
    logic        exp_drop;
    logic [3:0]  exp_drop_mask;
    logic [3:0]  exp_valid;
    logic [7:0]  exp_lane;
    logic        exp_ready_e1;
  } vec_t;

  vec_t vecs [6];

  initial begin
    logic [1:0] lane;
    logic [3:0] stale;

    vecs[0] = '{4'b1111, 16'h8421, 8'h10, 1'b0, 1'b0, 4'b0000, 4'b1111, 8'hE4, 1'b1};
    vecs[1] = '{4'b0101, 16'hF0F1, 8'h11, 1'b0, 1'b1, 4'b0100, 4'b0001, 8'h00, 1'b1};
    vecs[2] = '{4'b0000, 16'hFFFF, 8'h12, 1'b1, 1'b0, 4'b0000, 4'b0000, 8'h00, 1'b1};
    vecs[3] = '{4'b1011, 16'h0F00, 8'h13, 1'b1, 1'b1, 4'b1011, 4'b0000, 8'h00, 1'b1};
    vecs[4] = '{4'b0011, 16'h00AC, 8'h14, 1'b0, 1'b0, 4'b0000, 4'b0110, 8'h04, 1'b1};
    vecs[5] = '{4'b1111, 16'h6666, 8'h15, 1'b0, 1'b0, 4'b0000, 4'b0010, 8'h00, 1'b0};

    bus.in_valid     = 1'b0;
    bus.in_req_mask  = '0;
    bus.in_offset    = '0;
    bus.in_route_map = '0;
    bus.in_tag       = '0;
    bus.ch_ready     = 4'hF;

    #12;
    check("rst in_ready",   32'(bus.in_ready),   32'd1);
    check("rst ch_valid",   32'(bus.ch_valid),   32'd0);
    check("rst drop_valid", 32'(bus.drop_valid), 32'd0);
    check("rst perf",       bus.perf_stall_cnt,  32'd0);
    check("rst ch_offset0", 32'(bus.ch_offset[15:0]), 32'd0);
    step();
    rst_n = 1'b1;
    step();

    for (int v = 0; v < 6; v++) begin
      drive_bundle(v, vecs[v].mask, vecs[v].route, vecs[v].tag);
      step();
      check($sformatf("v%0d in_ready@E", v),   32'(bus.in_ready),   32'(vecs[v].exp_ready_e));
      check($sformatf("v%0d drop_valid@E", v), 32'(bus.drop_valid), 32'(vecs[v].exp_drop));
      if (vecs[v].exp_drop) begin
        check($sformatf("v%0d drop_mask", v), 32'(bus.drop_mask), 32'(vecs[v].exp_drop_mask));
        check($sformatf("v%0d drop_tag", v),  32'(bus.drop_tag),  32'(vecs[v].tag));
      end
      bus.in_valid = 1'b0;
      step();
      check($sformatf("v%0d ch_valid@E1", v),   32'(bus.ch_valid),   32'(vecs[v].exp_valid));
      check($sformatf("v%0d drop_valid@E1", v), 32'(bus.drop_valid), 32'd0);
      check($sformatf("v%0d in_ready@E1", v),   32'(bus.in_ready),   32'(vecs[v].exp_ready_e1));
      for (int j = 0; j < 4; j++) begin
        if (vecs[v].exp_valid[j]) begin
          lane = vecs[v].exp_lane[j*2 +: 2];
          check($sformatf("v%0d ch%0d lane", v, j),   32'(bus.ch_lane[j*2 +: 2]),    32'(lane));
          check($sformatf("v%0d ch%0d offset", v, j), 32'(bus.ch_offset[j*16 +: 16]), 32'(ofs_of(v, int'(lane))));
          check($sformatf("v%0d ch%0d tag", v, j),    32'(bus.ch_tag[j*8 +: 8]),     32'(vecs[v].tag));
        end
      end
      drain($sformatf("v%0d", v));
    end

    // All four lanes share channel 1: one lane per cycle in ascending order.
    drive_bundle(10, 4'b1111, 16'h6666, 8'hA5);
    step();
    check("shared in_ready@E", 32'(bus.in_ready), 32'd0);
    bus.in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      check($sformatf("shared ch_valid k%0d", k), 32'(bus.ch_valid),         32'b0010);
      check($sformatf("shared lane k%0d", k),     32'(bus.ch_lane[3:2]),     32'(k));
      check($sformatf("shared ofs k%0d", k),      32'(bus.ch_offset[31:16]), 32'(ofs_of(10, k)));
      check($sformatf("shared tag k%0d", k),      32'(bus.ch_tag[15:8]),     32'h0000_00A5);
      check($sformatf("shared in_ready k%0d", k), 32'(bus.in_ready),         32'(k == 3));
    end
    step();
    check("shared ch_valid after", 32'(bus.ch_valid), 32'd0);

    // Channel 0 held off for five cycles: outputs stable, stall counter advances.
    bus.ch_ready = 4'b1110;
    drive_bundle(11, 4'b0001, 16'h0001, 8'h5A);
    step();
    bus.in_valid = 1'b0;
    step();
    check("stall ch_valid@E1", 32'(bus.ch_valid), 32'b0001);
    for (int k = 0; k < 5; k++) begin
      step();
      check($sformatf("stall valid k%0d", k), 32'(bus.ch_valid[0]),      32'd1);
      check($sformatf("stall ofs k%0d", k),   32'(bus.ch_offset[15:0]),  32'(ofs_of(11, 0)));
      check($sformatf("stall tag k%0d", k),   32'(bus.ch_tag[7:0]),      32'h0000_005A);
    end
    check("stall perf held", bus.perf_stall_cnt, EXP_STALL);
    bus.ch_ready = 4'hF;
    step();
    check("stall released ch_valid", 32'(bus.ch_valid), 32'd0);
    check("stall perf after", bus.perf_stall_cnt, EXP_STALL);

    // Reset while two lanes of a bundle are still pending behind a blocked channel.
    bus.ch_ready = 4'b1011;
    drive_bundle(12, 4'b0111, 16'h0444, 8'h77);
    step();
    bus.in_valid = 1'b0;
    step();
    check("rstmid ch_valid pre",  32'(bus.ch_valid), 32'b0100);
    check("rstmid in_ready pre",  32'(bus.in_ready), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("rstmid ch_valid", 32'(bus.ch_valid), 32'd0);
    check("rstmid in_ready", 32'(bus.in_ready), 32'd1);
    check("rstmid perf",     bus.perf_stall_cnt, 32'd0);
    step();
    step();
    rst_n = 1'b1;
    bus.ch_ready = 4'hF;
    stale = 4'b0000;
    for (int k = 0; k < 6; k++) begin
      step();
      stale = stale | bus.ch_valid;
    end
    check("rstmid no stale", 32'(stale), 32'd0);
    check("rstmid in_ready after", 32'(bus.in_ready), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/match_req_dispatcher.md
MATCH_REQ_DISPATCHER -- requirements
Module: match_req_dispatcher

Interface
REQ-001 SHALL have parameter LAZY_LEN, default `LAZY_LEN, number of request lanes per bundle.
REQ-002 SHALL have parameter NUM_CH, default `NUM_MATCH_REQ_CH, number of match request channels.
REQ-003 SHALL have parameter OFS_BITS, default `SEQ_OFFSET_BITS, width of one offset.
REQ-004 SHALL have parameter TAG_BITS, default 8, width of the bundle tag.
REQ-005 SHALL have port clk, input, 1, the only clock.
REQ-006 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port in_valid, input, 1, bundle valid.
REQ-008 SHALL have port in_ready, output, 1, bundle accept.
REQ-009 SHALL have port in_req_mask, input, LAZY_LEN, lanes carrying a request.
REQ-010 SHALL have port in_offset, input, LAZY_LEN*OFS_BITS, per-lane offset, lane i at slice i.
REQ-011 SHALL have port in_route_map, input, LAZY_LEN*NUM_CH, route table output, bit i*NUM_CH+j means lane i eligible for channel j.
REQ-012 SHALL have port in_tag, input, TAG_BITS, bundle tag.
REQ-013 SHALL have ports ch_valid (output, NUM_CH), ch_ready (input, NUM_CH), ch_offset (output, NUM_CH*OFS_BITS), ch_lane (output, NUM_CH*clog2(LAZY_LEN)) and ch_tag (output, NUM_CH*TAG_BITS): per-channel request output.
REQ-014 SHALL have ports drop_valid (output, 1), drop_mask (output, LAZY_LEN) and drop_tag (output, TAG_BITS): report of unroutable lanes.
REQ-015 SHALL have port perf_stall_cnt, output, 32, backpressure stall counter.

Function
REQ-016 SHALL accept a bundle on a rising edge with in_valid and in_ready high; in_ready SHALL equal (state==IDLE).
REQ-017 Each requesting lane SHALL be bound at accept to the lowest-index channel j with its route bit set (smallest window first).
REQ-018 Requesting lanes with all route bits zero SHALL be unroutable: drop_valid SHALL pulse high for exactly the cycle after accept, with drop_mask = those lanes and drop_tag = in_tag.
REQ-019 The routable lanes SHALL form the pending mask; if it is empty at accept the FSM SHALL stay IDLE, otherwise it SHALL enter DISPATCH.
REQ-020 The FSM SHALL have exactly two states, IDLE and DISPATCH; DISPATCH->IDLE SHALL occur on the edge that clears the last pending bit.
REQ-021 Each channel SHALL have one output register; in DISPATCH, when ch_valid[j] is low or ch_ready[j] is high, it SHALL load the lowest-index pending lane bound to j and clear that pending bit on the same edge.
REQ-022 ch_valid[j] SHALL fall after a handshake when no pending lane is bound to j.
REQ-023 Minimum latency SHALL be accept at edge E, ch_valid high after edge E+1.
REQ-024 While ch_valid[j] is high and ch_ready[j] is low, ch_offset, ch_lane and ch_tag on channel j SHALL be held stable.
REQ-025 Lanes bound to distinct channels SHALL dispatch in the same cycle; lanes sharing a channel SHALL dispatch in ascending lane order, one per handshake.
REQ-026 Output registers MAY hold an earlier bundle's request while a new bundle is in DISPATCH; ordering per channel SHALL be preserved.
REQ-027 Offsets SHALL pass through unmodified; no arithmetic on offsets.

Reset
REQ-028 On rst_n low, asynchronously: state=IDLE, pending=0, ch_valid=0, drop_valid=0, perf_stall_cnt=0; data registers SHALL reset to 0.
REQ-029 Reset mid-DISPATCH SHALL discard all pending and in-flight requests without any further handshake.

Configuration
REQ-030 With MATCH_REQ_DISPATCH_PERF_EN defined, perf_stall_cnt SHALL increment by 1 each cycle in which any channel has ch_valid high and ch_ready low, saturating at 2^32-1.
REQ-031 Without MATCH_REQ_DISPATCH_PERF_EN, perf_stall_cnt SHALL be constant 0 and the counter SHALL not be synthesized.

Verification (LAZY_LEN=4, NUM_CH=4)
REQ-032 Mask 4'b1111, route lanes 0..3 to channels 0,1,2,3 (one-hot), all ch_ready=1 -> all four ch_valid high after E+1; in_ready high again one cycle later.
REQ-033 Mask 4'b1111, all lanes route 4'b0110 -> all bound to channel 1; ch_lane 0,1,2,3 on four consecutive cycles; other channels idle.
REQ-034 Mask 4'b0101, lane 2 route 4'b0000 -> drop_valid one cycle, drop_mask=4'b0100; only lane 0 dispatched.
REQ-035 Mask 4'b0000 or all lanes unroutable -> FSM stays IDLE, in_ready never falls, no ch_valid.
REQ-036 ch_ready[0]=0 for 5 cycles with lane 0 on channel 0 -> ch_offset[0] stable; perf_stall_cnt=5 with the macro, 0 without.
REQ-037 rst_n low mid-DISPATCH with 2 lanes pending -> ch_valid=0 immediately; after release in_ready=1, no stale requests appear.
